// File: rtl/npu_dispatch_ctrl.sv
// Purpose: launch/completion controller that dispatches CPU NPU requests round-robin to NUM_CH channels.
// Latency: ch_en rises LAUNCH_DELAY+1 edges after req_en is first sampled high; ack_cpu follows ch_ack by one edge.
// Backpressure: waits in SELECT while no channel is ready, and holds in DRAIN until the CPU drops req_en.
module npu_dispatch_ctrl #(
   parameter int NUM_CH       = 2,
   parameter int ADDR_W       = 10,
   parameter int LAUNCH_DELAY = 3,
   parameter int TIMEOUT      = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_en,
   input  logic [ADDR_W-1:0]   req_src1,
   input  logic [ADDR_W-1:0]   req_src2,
   input  logic [ADDR_W-1:0]   req_rd,
   output logic                ack_cpu,
   output logic                err_timeout,
   output logic                busy,
   output logic [2:0]          active_ch,
   input  logic [NUM_CH-1:0]   ch_ready,
   output logic [NUM_CH-1:0]   ch_en,
   output logic [ADDR_W-3:0]   ch_src1,
   output logic [ADDR_W-3:0]   ch_src2,
   output logic [ADDR_W-3:0]   ch_rd,
   input  logic [NUM_CH-1:0]   ch_ack
);

   localparam int SET_W = (LAUNCH_DELAY > 0) ? $clog2(LAUNCH_DELAY + 1) : 1;
   localparam int TO_W  = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_SELECT = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4,
      S_DRAIN  = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [SET_W-1:0]    settle_cnt;
   logic [TO_W-1:0]     to_cnt;
   logic                to_flag;
   logic [2:0]          rr_ptr;
   logic [NUM_CH-1:0]   run_mask;
   logic                ack_hit;
   logic                to_hit;
   logic                settle_done;
   logic [7:0]          ready_pad;
   logic [3:0]          scan;
   logic                sel_vld;
   logic [2:0]          sel_idx;

   // Byte-offset bits of the operand addresses are dropped; channels take word addresses.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{req_src1[1:0], req_src2[1:0], req_rd[1:0]};

   assign run_mask    = NUM_CH'(1) << active_ch;
   assign ack_hit     = |(ch_ack & run_mask);
   assign to_hit      = (to_cnt == TO_W'(TIMEOUT - 1));
   assign settle_done = (settle_cnt == SET_W'(LAUNCH_DELAY));
   assign ready_pad   = 8'(ch_ready);

   // Round-robin scan: first ready channel strictly after the last one dispatched, wrapping at NUM_CH.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = 3'd0;
      scan    = 4'd0;
      for (int i = 1; i <= NUM_CH; i++) begin
         scan = 4'(rr_ptr) + 4'(i);
         if (scan >= 4'(NUM_CH)) begin
            scan = scan - 4'(NUM_CH);
         end
         if (!sel_vld && ready_pad[scan[2:0]]) begin
            sel_vld = 1'b1;
            sel_idx = scan[2:0];
         end
      end
   end

   // State register; reset drops straight to IDLE, abandoning any operation without an ack.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (req_en) begin
               state_nxt = (LAUNCH_DELAY == 0) ? S_SELECT : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!req_en) begin
               state_nxt = S_IDLE;
            end else if (settle_done) begin
               state_nxt = S_SELECT;
            end
         end
         S_SELECT: begin
            if (!req_en) begin
               state_nxt = S_IDLE;
            end else if (sel_vld) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (ack_hit || to_hit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!req_en) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; ch_en only while RUN so any exit (ack, abort, reset) drops it at once.
   always_comb begin
      ack_cpu     = (state == S_DONE);
      err_timeout = (state == S_DONE) && to_flag;
      busy        = (state != S_IDLE);
      ch_en       = (state == S_RUN) ? run_mask : '0;
   end

   // Counters, round-robin pointer and latched operand addresses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         settle_cnt <= '0;
         to_cnt     <= '0;
         to_flag    <= 1'b0;
         rr_ptr     <= 3'(NUM_CH - 1);
         active_ch  <= 3'd0;
         ch_src1    <= '0;
         ch_src2    <= '0;
         ch_rd      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_en) begin
                  settle_cnt <= SET_W'(1);
               end
            end
            S_SETTLE: begin
               if (req_en && !settle_done) begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            S_SELECT: begin
               if (req_en && sel_vld) begin
                  ch_src1   <= req_src1[ADDR_W-1:2];
                  ch_src2   <= req_src2[ADDR_W-1:2];
                  ch_rd     <= req_rd[ADDR_W-1:2];
                  active_ch <= sel_idx;
                  rr_ptr    <= sel_idx;
                  to_cnt    <= '0;
                  to_flag   <= 1'b0;
               end
            end
            S_RUN: begin
               // Only meaningful on the exit edge: set when leaving without an ack, so ack beats timeout.
               to_flag <= !ack_hit;
               if (!ack_hit && !to_hit) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_npu_dispatch_ctrl.sv
// Purpose: directed table-driven bench for npu_dispatch_ctrl (NUM_CH=2, LAUNCH_DELAY=3, TIMEOUT=16).
// Latency: checks dispatch at E+LAUNCH_DELAY+1, one-cycle ack_cpu, timeout 16 cycles after dispatch.
// Backpressure: exercises SELECT stall with no ready channel and DRAIN hold while req_en stays high.
module tb_npu_dispatch_ctrl;

   logic       clk;
   logic       rst;
   logic       req_en;
   logic [9:0] req_src1;
   logic [9:0] req_src2;
   logic [9:0] req_rd;
   logic       ack_cpu;
   logic       err_timeout;
   logic       busy;
   logic [2:0] active_ch;
   logic [1:0] ch_ready;
   logic [1:0] ch_en;
   logic [7:0] ch_src1;
   logic [7:0] ch_src2;
   logic [7:0] ch_rd;
   logic [1:0] ch_ack;

   int n_pass;
   int n_total;

   typedef struct {
      logic [9:0] src1;
      logic [9:0] src2;
      logic [9:0] rd;
      logic [1:0] ready;
      logic [2:0] exp_ch;
      logic [1:0] exp_en;
      logic [7:0] exp_w1;
      logic [7:0] exp_w2;
      logic [7:0] exp_wr;
   } vec_t;

   vec_t vecs[8];

   npu_dispatch_ctrl #(
      .NUM_CH(2), .ADDR_W(10), .LAUNCH_DELAY(3), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .req_en(req_en),
      .req_src1(req_src1), .req_src2(req_src2), .req_rd(req_rd),
      .ack_cpu(ack_cpu), .err_timeout(err_timeout), .busy(busy),
      .active_ch(active_ch), .ch_ready(ch_ready), .ch_en(ch_en),
      .ch_src1(ch_src1), .ch_src2(ch_src2), .ch_rd(ch_rd), .ch_ack(ch_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      n_pass  = 0;
      n_total = 0;

      // Round-robin starts at ch0 after reset; pointer then follows each pick.
      vecs[0] = '{10'h104, 10'h208, 10'h30C, 2'b11, 3'd0, 2'b01, 8'h41, 8'h82, 8'hC3};
      vecs[1] = '{10'h3FC, 10'h001, 10'h155, 2'b11, 3'd1, 2'b10, 8'hFF, 8'h00, 8'h55};
      vecs[2] = '{10'h3FF, 10'h2A1, 10'h0F0, 2'b11, 3'd0, 2'b01, 8'hFF, 8'hA8, 8'h3C};
      vecs[3] = '{10'h010, 10'h020, 10'h040, 2'b01, 3'd0, 2'b01, 8'h04, 8'h08, 8'h10};
      vecs[4] = '{10'h123, 10'h246, 10'h38C, 2'b01, 3'd0, 2'b01, 8'h48, 8'h91, 8'hE3};
      vecs[5] = '{10'h004, 10'h008, 10'h00C, 2'b10, 3'd1, 2'b10, 8'h01, 8'h02, 8'h03};
      vecs[6] = '{10'h200, 10'h100, 10'h080, 2'b10, 3'd1, 2'b10, 8'h80, 8'h40, 8'h20};
      vecs[7] = '{10'h0AB, 10'h0CD, 10'h0EF, 2'b11, 3'd0, 2'b01, 8'h2A, 8'h33, 8'h3B};

      // Reset with busy-looking inputs: nothing may leak through.
      rst = 1'b0; req_en = 1'b1; ch_ready = 2'b11; ch_ack = 2'b11;
      req_src1 = 10'h3FF; req_src2 = 10'h3FF; req_rd = 10'h3FF;
      repeat (3) tick();
      chk("rst_ack_cpu", 32'(ack_cpu), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ch_en", 32'(ch_en), 32'd0);
      chk("rst_active_ch", 32'(active_ch), 32'd0);
      chk("rst_ch_src1", 32'(ch_src1), 32'd0);
      chk("rst_ch_src2", 32'(ch_src2), 32'd0);
      chk("rst_ch_rd", 32'(ch_rd), 32'd0);
      req_en = 1'b0; ch_ack = 2'b00;
      rst = 1'b1;
      tick();

      // Table of full transactions.
      for (int v = 0; v < 8; v++) begin
         req_en   = 1'b1;
         req_src1 = vecs[v].src1;
         req_src2 = vecs[v].src2;
         req_rd   = vecs[v].rd;
         ch_ready = vecs[v].ready;
         tick();                                  // edge E
         chk("settle_busy", 32'(busy), 32'd1);
         repeat (3) tick();                       // E+3
         chk("pre_dispatch_ch_en", 32'(ch_en), 32'd0);
         tick();                                  // E+4
         chk("dispatch_ch_en", 32'(ch_en), 32'(vecs[v].exp_en));
         chk("dispatch_active_ch", 32'(active_ch), 32'(vecs[v].exp_ch));
         chk("ch_src1", 32'(ch_src1), 32'(vecs[v].exp_w1));
         chk("ch_src2", 32'(ch_src2), 32'(vecs[v].exp_w2));
         chk("ch_rd", 32'(ch_rd), 32'(vecs[v].exp_wr));
         ch_ack = ~vecs[v].exp_en;
         tick();
         ch_ack = 2'b00;
         chk("wrong_ack_ch_en", 32'(ch_en), 32'(vecs[v].exp_en));
         chk("wrong_ack_ack_cpu", 32'(ack_cpu), 32'd0);
         ch_ack = vecs[v].exp_en;
         tick();
         ch_ack = 2'b00;
         chk("ack_cpu_pulse", 32'(ack_cpu), 32'd1);
         chk("ack_err", 32'(err_timeout), 32'd0);
         chk("ack_ch_en_drop", 32'(ch_en), 32'd0);
         tick();
         chk("ack_single_cycle", 32'(ack_cpu), 32'd0);
         chk("drain_busy", 32'(busy), 32'd1);
         repeat (2) tick();
         chk("drain_no_retrigger", 32'(ch_en), 32'd0);
         chk("drain_words_stable", 32'(ch_src1), 32'(vecs[v].exp_w1));
         req_en = 1'b0;
         tick();
         chk("idle_after_drop", 32'(busy), 32'd0);
      end

      // Aborted settle: req_en high for two edges only.
      req_en = 1'b1; ch_ready = 2'b11;
      tick();
      chk("abort_settle_busy", 32'(busy), 32'd1);
      tick();
      req_en = 1'b0;
      tick();
      chk("abort_idle", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (ch_en != 2'b00 || ack_cpu) seen = 1'b1;
      end
      chk("abort_no_dispatch", 32'(seen), 32'd0);

      // Timeout with no ack; pointer is at ch0 so ch1 is picked.
      req_en = 1'b1; ch_ready = 2'b11;
      repeat (5) tick();
      chk("to_dispatch", 32'(ch_en), 32'b10);
      repeat (15) tick();
      chk("to_hold_ch_en", 32'(ch_en), 32'b10);
      chk("to_hold_ack", 32'(ack_cpu), 32'd0);
      tick();
      chk("to_ch_en_drop", 32'(ch_en), 32'd0);
      chk("to_ack_cpu", 32'(ack_cpu), 32'd1);
      chk("to_err", 32'(err_timeout), 32'd1);
      tick();
      chk("to_ack_single", 32'(ack_cpu), 32'd0);
      chk("to_err_single", 32'(err_timeout), 32'd0);
      req_en = 1'b0;
      tick();

      // Ack coincident with the timeout edge: ack wins.
      req_en = 1'b1; ch_ready = 2'b11;
      repeat (5) tick();
      chk("coinc_dispatch", 32'(ch_en), 32'b01);
      repeat (15) tick();
      ch_ack = 2'b01;
      tick();
      ch_ack = 2'b00;
      chk("coinc_ack_cpu", 32'(ack_cpu), 32'd1);
      chk("coinc_err", 32'(err_timeout), 32'd0);
      tick();
      req_en = 1'b0;
      tick();

      // Stall in SELECT with no ready channel, then dispatch right after ready rises.
      req_en = 1'b1; ch_ready = 2'b00;
      repeat (4) tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_ch_en", 32'(ch_en), 32'd0);
      end
      chk("stall_busy", 32'(busy), 32'd1);
      ch_ready = 2'b10;
      tick();
      chk("stall_dispatch_ch_en", 32'(ch_en), 32'b10);
      chk("stall_active_ch", 32'(active_ch), 32'd1);
      ch_ack = 2'b10;
      tick();
      ch_ack = 2'b00;
      chk("stall_ack_cpu", 32'(ack_cpu), 32'd1);
      tick();
      req_en = 1'b0;
      tick();

      // Reset in the middle of RUN on ch1.
      req_en = 1'b1; ch_ready = 2'b10;
      repeat (5) tick();
      chk("mid_rst_dispatch", 32'(ch_en), 32'b10);
      repeat (3) tick();
      rst = 1'b0; req_en = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_rst_ch_en", 32'(ch_en), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ack", 32'(ack_cpu), 32'd0);
      chk("mid_rst_active_ch", 32'(active_ch), 32'd0);
      seen = 1'b0;
      repeat (4) begin
         tick();
         if (ack_cpu) seen = 1'b1;
      end
      chk("mid_rst_no_ack", 32'(seen), 32'd0);
      req_en = 1'b1; ch_ready = 2'b11;
      repeat (5) tick();
      chk("post_rst_ch_en", 32'(ch_en), 32'b01);
      chk("post_rst_active_ch", 32'(active_ch), 32'd0);
      ch_ack = 2'b01;
      tick();
      ch_ack = 2'b00;
      chk("post_rst_ack_cpu", 32'(ack_cpu), 32'd1);
      req_en = 1'b0;
      repeat (2) tick();
      chk("post_rst_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
